// File: rtl/bitnet_pkg.sv
// Shared enums for the streaming majority voter.
package bitnet_pkg;

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_t;

    typedef enum logic {
        MODE_FWD = 1'b0,
        MODE_BWD = 1'b1
    } mode_t;

endpackage

// File: rtl/popcount_n.sv
// Combinational population count built as a recursive balanced adder tree.
module popcount_n #(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0]               data,
    output logic [$clog2(WIDTH+1)-1:0]     count
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    generate
        if (WIDTH == 1) begin : g_leaf
            assign count = data;
        end else begin : g_split
            localparam int unsigned LO = WIDTH / 2;
            localparam int unsigned HI = WIDTH - LO;

            logic [$clog2(LO+1)-1:0] lo_cnt;
            logic [$clog2(HI+1)-1:0] hi_cnt;

            popcount_n #(.WIDTH(LO)) u_lo (
                .data  (data[LO-1:0]),
                .count (lo_cnt)
            );

            popcount_n #(.WIDTH(HI)) u_hi (
                .data  (data[WIDTH-1:LO]),
                .count (hi_cnt)
            );

            assign count = CW'(lo_cnt) + CW'(hi_cnt);
        end
    endgenerate

endmodule

// File: rtl/pmaj_stream.sv
// Streaming majority voter: accumulates BEATS beats of WIDTH vote bits and
// emits one replicated result bit per vote over a valid/ready handshake.
module pmaj_stream
    import bitnet_pkg::*;
#(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned BEATS     = 1,
    parameter int unsigned OUT_WIDTH = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 mode_in,
    input  logic                 control_in,
    input  logic                 s_valid_in,
    output logic                 s_ready_out,
    input  logic [WIDTH-1:0]     s_data_in,
    output logic                 m_valid_out,
    input  logic                 m_ready_in,
    output logic [OUT_WIDTH-1:0] m_data_out,
    output logic                 m_control_out
);

    localparam int unsigned N  = WIDTH * BEATS;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned PW = $clog2(WIDTH + 1);
    localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t          state;
    logic [CW-1:0]   count;
    logic [BW-1:0]   beat_cnt;
    mode_t           mode_q;
    logic            ctrl_q;
    logic            valid_q;
    logic            result_q;
    logic            ctl_out_q;

    logic [PW-1:0]   beat_pop;
    logic            first_beat;
    logic            last_beat;
    mode_t           mode_eff;
    logic            ctrl_eff;
    logic [CW-1:0]   sum;
    logic [31:0]     twice_sum;
    logic            vote;

    popcount_n #(.WIDTH(WIDTH)) u_pop (
        .data  (s_data_in),
        .count (beat_pop)
    );

    // On the first beat the live mode/control apply; later beats use the latched copy.
    always_comb begin
        first_beat = (beat_cnt == '0);
        last_beat  = (32'(beat_cnt) == BEATS - 1);
        mode_eff   = first_beat ? mode_t'(mode_in) : mode_q;
        ctrl_eff   = first_beat ? control_in : ctrl_q;
        sum        = CW'(32'(count) + 32'(beat_pop));
        twice_sum  = 32'(sum) << 1;
        if (twice_sum > N) begin
            vote = 1'b1;
        end else if (twice_sum < N) begin
            vote = 1'b0;
        end else begin
            vote = (mode_eff == MODE_FWD) ? ctrl_eff : 1'b0;
        end
    end

    // Ready is gated by reset so no beat is accepted in a reset cycle.
    assign s_ready_out   = (state == ACCUM) && !rst_in;
    assign m_valid_out   = valid_q;
    assign m_data_out    = {OUT_WIDTH{result_q}};
    assign m_control_out = ctl_out_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= ACCUM;
            count     <= '0;
            beat_cnt  <= '0;
            mode_q    <= MODE_FWD;
            ctrl_q    <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= 1'b0;
            ctl_out_q <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (s_valid_in) begin
                        if (first_beat) begin
                            mode_q <= mode_t'(mode_in);
                            ctrl_q <= control_in;
                        end
                        if (last_beat) begin
                            result_q  <= vote;
                            ctl_out_q <= (mode_eff == MODE_BWD) && vote;
                            count     <= '0;
                            beat_cnt  <= '0;
                            valid_q   <= 1'b1;
                            state     <= OUTPUT;
                        end else begin
                            count    <= sum;
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end
                OUTPUT: begin
                    if (m_ready_in) begin
                        valid_q <= 1'b0;
                        state   <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmaj_stream.sv
// Directed bench for pmaj_stream: a single-beat instance (3x1) and a
// two-beat instance (4x2) driven from vector tables plus corner sequences.
module tb_pmaj_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A: WIDTH=3, BEATS=1
    logic       rst_a, mode_a, ctrl_a, sv_a, srdy_a, mv_a, mrdy_a, mc_a;
    logic [2:0] sd_a, md_a;

    // Instance B: WIDTH=4, BEATS=2
    logic       rst_b, mode_b, ctrl_b, sv_b, srdy_b, mv_b, mrdy_b, mc_b;
    logic [3:0] sd_b;
    logic [2:0] md_b;

    pmaj_stream #(.WIDTH(3), .BEATS(1), .OUT_WIDTH(3)) u_dut_a (
        .clk_in        (clk),
        .rst_in        (rst_a),
        .mode_in       (mode_a),
        .control_in    (ctrl_a),
        .s_valid_in    (sv_a),
        .s_ready_out   (srdy_a),
        .s_data_in     (sd_a),
        .m_valid_out   (mv_a),
        .m_ready_in    (mrdy_a),
        .m_data_out    (md_a),
        .m_control_out (mc_a)
    );

    pmaj_stream #(.WIDTH(4), .BEATS(2), .OUT_WIDTH(3)) u_dut_b (
        .clk_in        (clk),
        .rst_in        (rst_b),
        .mode_in       (mode_b),
        .control_in    (ctrl_b),
        .s_valid_in    (sv_b),
        .s_ready_out   (srdy_b),
        .s_data_in     (sd_b),
        .m_valid_out   (mv_b),
        .m_ready_in    (mrdy_b),
        .m_data_out    (md_b),
        .m_control_out (mc_b)
    );

    typedef struct {
        logic       mode;
        logic       ctrl;
        logic [2:0] d;
        logic [2:0] exp_data;
        logic       exp_ctl;
    } va_t;

    typedef struct {
        logic       mode;
        logic       ctrl;
        logic [3:0] d0;
        logic [3:0] d1;
        logic [2:0] exp_data;
        logic       exp_ctl;
    } vb_t;

    va_t tab_a [5];
    vb_t tab_b [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_maj(input logic [3:0] a, input logic [3:0] b,
                                     input logic mode, input logic ctrl);
        int c;
        c = $countones(a) + $countones(b);
        if (2 * c > 8) return 1'b1;
        if (2 * c < 8) return 1'b0;
        return mode ? 1'b0 : ctrl;
    endfunction

    task automatic vote_a(input va_t v, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        sv_a = 1'b1; sd_a = v.d; mode_a = v.mode; ctrl_a = v.ctrl;
        while (!srdy_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(srdy_a), 32'd1);
        @(posedge clk);
        #1 sv_a = 1'b0;
        @(negedge clk);
        check({tag, "_valid"}, 32'(mv_a), 32'd1);
        check({tag, "_data"}, 32'(md_a), 32'(v.exp_data));
        check({tag, "_ctl"}, 32'(mc_a), 32'(v.exp_ctl));
        mrdy_a = 1'b1;
        @(posedge clk);
        #1 mrdy_a = 1'b0;
    endtask

    task automatic beat_b(input logic [3:0] d, input logic m, input logic c);
        int n;
        n = 0;
        @(negedge clk);
        sv_b = 1'b1; sd_b = d; mode_b = m; ctrl_b = c;
        while (!srdy_b && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!srdy_b) check("beat_b_ready_timeout", 32'(srdy_b), 32'd1);
        @(posedge clk);
        #1 sv_b = 1'b0;
    endtask

    task automatic collect_b(input string tag);
        mrdy_b = 1'b1;
        @(posedge clk);
        #1 mrdy_b = 1'b0;
        @(negedge clk);
        check({tag, "_drop"}, 32'(mv_b), 32'd0);
        check({tag, "_rdy_back"}, 32'(srdy_b), 32'd1);
    endtask

    // Second beat carries inverted mode/control, which must be ignored.
    task automatic vote_b(input vb_t v, input int gap, input string tag);
        beat_b(v.d0, v.mode, v.ctrl);
        repeat (gap) @(negedge clk);
        beat_b(v.d1, ~v.mode, ~v.ctrl);
        @(negedge clk);
        check({tag, "_valid"}, 32'(mv_b), 32'd1);
        check({tag, "_data"}, 32'(md_b), 32'(v.exp_data));
        check({tag, "_ctl"}, 32'(mc_b), 32'(v.exp_ctl));
        check({tag, "_rdy_out"}, 32'(srdy_b), 32'd0);
        collect_b(tag);
    endtask

    localparam int NV = 6;
    logic [3:0] bb_d [2*NV];
    logic       bb_mode [NV];
    logic       bb_ctrl [NV];

    initial begin
        tab_a[0] = '{1'b0, 1'b0, 3'b110, 3'b111, 1'b0};
        tab_a[1] = '{1'b0, 1'b1, 3'b100, 3'b000, 1'b0};
        tab_a[2] = '{1'b1, 1'b0, 3'b011, 3'b111, 1'b1};
        tab_a[3] = '{1'b0, 1'b1, 3'b111, 3'b111, 1'b0};
        tab_a[4] = '{1'b1, 1'b1, 3'b000, 3'b000, 1'b0};

        tab_b[0] = '{1'b0, 1'b1, 4'b1100, 4'b0011, 3'b111, 1'b0};
        tab_b[1] = '{1'b1, 1'b0, 4'b1100, 4'b0011, 3'b000, 1'b0};
        tab_b[2] = '{1'b1, 1'b0, 4'b1110, 4'b0111, 3'b111, 1'b1};
        tab_b[3] = '{1'b0, 1'b0, 4'b1100, 4'b0011, 3'b000, 1'b0};
        tab_b[4] = '{1'b0, 1'b0, 4'b1111, 4'b0001, 3'b111, 1'b0};
        tab_b[5] = '{1'b1, 1'b1, 4'b0001, 4'b0000, 3'b000, 1'b0};
        tab_b[6] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 3'b000, 1'b0};
        tab_b[7] = '{1'b1, 1'b0, 4'b1111, 4'b1111, 3'b111, 1'b1};
        tab_b[8] = '{1'b0, 1'b1, 4'b0111, 4'b0000, 3'b000, 1'b0};

        bb_d[0] = 4'b1100; bb_d[1]  = 4'b0011;
        bb_d[2] = 4'b1100; bb_d[3]  = 4'b0011;
        bb_d[4] = 4'b1111; bb_d[5]  = 4'b0111;
        bb_d[6] = 4'b1010; bb_d[7]  = 4'b0101;
        bb_d[8] = 4'b0001; bb_d[9]  = 4'b0010;
        bb_d[10] = 4'b1110; bb_d[11] = 4'b1101;
        for (int i = 0; i < NV; i++) begin
            bb_mode[i] = (i == 3);
            bb_ctrl[i] = (i % 2 == 0);
        end

        rst_a = 1'b1; mode_a = 1'b0; ctrl_a = 1'b0; sv_a = 1'b0; sd_a = '0; mrdy_a = 1'b0;
        rst_b = 1'b1; mode_b = 1'b0; ctrl_b = 1'b0; sv_b = 1'b0; sd_b = '0; mrdy_b = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_a_ready", 32'(srdy_a), 32'd0);
        check("rst_a_valid", 32'(mv_a), 32'd0);
        check("rst_a_data", 32'(md_a), 32'd0);
        check("rst_b_ready", 32'(srdy_b), 32'd0);
        check("rst_b_valid", 32'(mv_b), 32'd0);
        check("rst_b_ctl", 32'(mc_b), 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        check("post_rst_a_ready", 32'(srdy_a), 32'd1);
        check("post_rst_b_ready", 32'(srdy_b), 32'd1);

        for (int i = 0; i < 5; i++) vote_a(tab_a[i], $sformatf("a%0d", i));
        for (int i = 0; i < 9; i++) vote_b(tab_b[i], 0, $sformatf("b%0d", i));

        // Gapped input must give the same result as ungapped.
        vote_b(tab_b[2], 3, "gap");
        vote_b(tab_b[0], 2, "gap_tie");

        // Downstream stall: result must hold and no beat may be accepted.
        beat_b(4'b1110, 1'b1, 1'b0);
        beat_b(4'b0111, 1'b0, 1'b1);
        sv_b = 1'b1; sd_b = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(mv_b), 32'd1);
            check("stall_data", 32'(md_b), 32'h7);
            check("stall_ctl", 32'(mc_b), 32'd1);
            check("stall_ready", 32'(srdy_b), 32'd0);
        end
        sv_b = 1'b0;
        collect_b("stall");
        vote_b(tab_b[5], 0, "after_stall");

        // Reset mid-vote discards the partial count.
        beat_b(4'b1111, 1'b0, 1'b1);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("midrst_ready", 32'(srdy_b), 32'd0);
        rst_b = 1'b0;
        #1 check("midrst_ready_after", 32'(srdy_b), 32'd1);
        begin
            vb_t v;
            v = '{1'b0, 1'b1, 4'b0000, 4'b0001, 3'b000, 1'b0};
            vote_b(v, 0, "midrst");
        end

        // Reset while a result is pending drops it.
        beat_b(4'b1111, 1'b1, 1'b0);
        beat_b(4'b1111, 1'b1, 1'b0);
        @(negedge clk);
        check("outrst_pre_valid", 32'(mv_b), 32'd1);
        rst_b = 1'b1;
        @(negedge clk);
        check("outrst_valid", 32'(mv_b), 32'd0);
        check("outrst_data", 32'(md_b), 32'd0);
        check("outrst_ctl", 32'(mc_b), 32'd0);
        rst_b = 1'b0;
        #1 check("outrst_ready", 32'(srdy_b), 32'd1);

        // Back-to-back votes with both handshakes held high.
        begin
            int idx, got, last;
            logic acc, e;
            idx = 0; got = 0; last = 0;
            mrdy_b = 1'b1;
            for (int cyc = 0; cyc < 80 && got < NV; cyc++) begin
                @(negedge clk);
                if (mv_b) begin
                    e = ref_maj(bb_d[2*got], bb_d[2*got+1], bb_mode[got], bb_ctrl[got]);
                    check("b2b_data", 32'(md_b), 32'({3{e}}));
                    check("b2b_ctl", 32'(mc_b), 32'(bb_mode[got] & e));
                    if (got > 0) check("b2b_period", 32'(cyc - last), 32'd3);
                    last = cyc;
                    got++;
                end
                if (idx < 2 * NV) begin
                    sv_b = 1'b1; sd_b = bb_d[idx];
                    mode_b = bb_mode[idx/2]; ctrl_b = bb_ctrl[idx/2];
                end else begin
                    sv_b = 1'b0;
                end
                acc = srdy_b && sv_b;
                @(posedge clk);
                #1;
                if (acc) idx++;
            end
            check("b2b_count", 32'(got), 32'(NV));
            sv_b = 1'b0; mrdy_b = 1'b0;
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
